// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bit order, hex glyph codes, blank code.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

    // A segment code is {g,f,e,d,c,b,a}: bit 0 drives segment a, bit 6 drives g.
    // Codes below are active-high (1 = segment lit).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [6:0] seg_code_t;

    localparam seg_code_t SEG_0     = 7'h3F;
    localparam seg_code_t SEG_1     = 7'h06;
    localparam seg_code_t SEG_2     = 7'h5B;
    localparam seg_code_t SEG_3     = 7'h4F;
    localparam seg_code_t SEG_4     = 7'h66;
    localparam seg_code_t SEG_5     = 7'h6D;
    localparam seg_code_t SEG_6     = 7'h7D;
    localparam seg_code_t SEG_7     = 7'h07;
    localparam seg_code_t SEG_8     = 7'h7F;
    localparam seg_code_t SEG_9     = 7'h6F;
    localparam seg_code_t SEG_HEX_A = 7'h77;
    localparam seg_code_t SEG_HEX_B = 7'h7C;
    localparam seg_code_t SEG_HEX_C = 7'h39;
    localparam seg_code_t SEG_HEX_D = 7'h5E;
    localparam seg_code_t SEG_HEX_E = 7'h79;
    localparam seg_code_t SEG_HEX_F = 7'h71;
    localparam seg_code_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-high seven-segment glyph decoder.
// Latency: combinational, zero cycles.
// Backpressure: none. Ports: nibble (4b in), seg (7b {g..a} out).
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_code_t  seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with PWM brightness and shadowed display data.
// Latency: outputs registered, one cycle behind the scan counter; load visible one edge after capture.
// Backpressure: none; load accepted every cycle. Ports: clk, rst_n, digits_in/dp_in/digit_en/brightness/load in; an/seg/dp/slot_tick out.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV        = 100000,
    parameter int DUTY_W     = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DUTY_W-1:0]     brightness,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  slot_tick
);

    localparam int Q_CNT = DIV / (2 ** DUTY_W);
    localparam int Q_W   = (Q_CNT > 1) ? $clog2(Q_CNT) : 1;
    localparam int K_W   = $clog2(DIGITS);

    localparam logic [Q_W-1:0]    Q_LAST = Q_W'(Q_CNT - 1);
    localparam logic [DUTY_W-1:0] P_LAST = {DUTY_W{1'b1}};
    localparam logic [K_W-1:0]    K_LAST = K_W'(DIGITS - 1);

    // XOR masks that turn active-high internal values into pin polarity;
    // they are also the inactive (dark) pin levels.
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};

    logic                  run;
    logic [Q_W-1:0]        q;
    logic [DUTY_W-1:0]     p;
    logic [K_W-1:0]        k;

    logic [4*DIGITS-1:0]   digits_sh;
    logic [DIGITS-1:0]     dp_sh;
    logic [DIGITS-1:0]     en_sh;
    logic [DUTY_W-1:0]     bright_sh;

    logic                  dead;
    logic                  lit;
    logic [DIGITS-1:0]     an_sel;
    seg_code_t             seg_hex;

    // Release synchroniser: the first edge after rst_n rises only arms the
    // scanner, so the counters leave (0,0,0) on the second edge and the
    // first slot_tick lands there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Prescaler (q: cycles within a sub-phase, p: sub-phase) and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
            p <= '0;
            k <= '0;
        end else if (run) begin
            if (q == Q_LAST) begin
                q <= '0;
                p <= p + 1'b1;  // P_LAST is all ones, so p wraps by itself
                if (p == P_LAST) begin
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                end
            end else begin
                q <= q + 1'b1;
            end
        end
    end

    // Shadow registers: the only source of display content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_sh <= '0;
            dp_sh     <= '0;
            en_sh     <= '0;
            bright_sh <= '0;
        end else if (load) begin
            digits_sh <= digits_in;
            dp_sh     <= dp_in;
            en_sh     <= digit_en;
            bright_sh <= brightness;
        end
    end

    hex7seg u_hex7seg (
        .nibble (digits_sh[4*k +: 4]),
        .seg    (seg_hex)
    );

    // The first cycle of every slot stays dark so the previous digit's anode
    // can discharge before the next digit's segments appear.
    assign dead = (p == '0) && (q == '0);
    assign lit  = en_sh[k] && (p < bright_sh) && !dead;

    always_comb begin
        an_sel    = '0;
        an_sel[k] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= ACTIVE_LOW;
            slot_tick <= 1'b0;
        end else if (!run) begin
            an        <= AN_OFF;
            seg       <= SEG_OFF;
            dp        <= ACTIVE_LOW;
            slot_tick <= 1'b0;
        end else begin
            an        <= (lit ? an_sel : '0) ^ AN_OFF;
            seg       <= (lit ? seg_hex : SEG_BLANK) ^ SEG_OFF;
            dp        <= (lit & dp_sh[k]) ^ ACTIVE_LOW;
            slot_tick <= dead;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 16;
    localparam int DUTY_W = 2;
    localparam int SUBLEN = DIV / (1 << DUTY_W);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [1:0]  brightness = '0;
    logic        load = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        slot_tick;

    seg_scan_driver #(
        .DIGITS     (DIGITS),
        .DIV        (DIV),
        .DUTY_W     (DUTY_W),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .brightness (brightness),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .slot_tick  (slot_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } obs_t;

    obs_t       exp_q[$];
    logic [6:0] hex_ref [16];

    // Reference model state: t_m counts running edges since the scanner armed.
    bit          run_m = 1'b0;
    int          t_m = 0;
    logic [15:0] dig_m = '0;
    logic [3:0]  dpm = '0;
    logic [3:0]  enm = '0;
    logic [1:0]  brm = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int prev_tick = -1;
    int gap_bad = 0;
    int tick_cnt = 0;
    int lit_cnt [4];
    int d0_79_cnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        run_m = 1'b0;
        t_m   = 0;
        dig_m = '0;
        dpm   = '0;
        enm   = '0;
        brm   = '0;
        prev_tick = -1;
    endtask

    // One clock: predict the coming edge, push it, then sample at the falling edge.
    task automatic cycle();
        obs_t e;
        obs_t got;
        int   k;
        int   off;
        bit   lit;
        logic [3:0] one;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = 1'b0;
        if (rst_n) begin
            if (run_m) begin
                off    = t_m % DIV;
                k      = (t_m / DIV) % DIGITS;
                e.tick = (off == 0);
                lit    = enm[k] && ((off / SUBLEN) < int'(brm)) && (off != 0);
                if (lit) begin
                    one   = 4'b0001 << k;
                    e.an  = ~one;
                    e.seg = ~hex_ref[dig_m[4*k +: 4]];
                    e.dp  = ~dpm[k];
                end
                t_m++;
            end
            run_m = 1'b1;
            if (load) begin
                dig_m = digits_in;
                dpm   = dp_in;
                enm   = digit_en;
                brm   = brightness;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        got = {an, seg, dp, slot_tick};
        e   = exp_q.pop_front();
        n_cmp++;
        assert (got === e) else begin
            n_bad++;
            $error("FAIL scoreboard cyc=%0d got an=%b seg=%h dp=%b tick=%b exp an=%b seg=%h dp=%b tick=%b",
                   cyc, got.an, got.seg, got.dp, got.tick, e.an, e.seg, e.dp, e.tick);
        end
        for (int i = 0; i < 4; i++) begin
            one = 4'b0001 << i;
            if (an === ~one) lit_cnt[i]++;
        end
        if (an === 4'b1110 && seg === 7'h79) d0_79_cnt++;
        if (slot_tick === 1'b1) begin
            tick_cnt++;
            if (prev_tick >= 0 && (cyc - prev_tick) != DIV) gap_bad++;
            prev_tick = cyc;
        end
    endtask

    task automatic window(input int n);
        for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
        tick_cnt  = 0;
        d0_79_cnt = 0;
        repeat (n) cycle();
    endtask

    task automatic chk_lits(input string name, input int l0, input int l1, input int l2, input int l3);
        chk({name, "_d0"}, lit_cnt[0], l0);
        chk({name, "_d1"}, lit_cnt[1], l1);
        chk({name, "_d2"}, lit_cnt[2], l2);
        chk({name, "_d3"}, lit_cnt[3], l3);
        chk({name, "_ticks"}, tick_cnt, 4);
    endtask

    initial begin
        hex_ref[0]  = 7'h3F; hex_ref[1]  = 7'h06; hex_ref[2]  = 7'h5B; hex_ref[3]  = 7'h4F;
        hex_ref[4]  = 7'h66; hex_ref[5]  = 7'h6D; hex_ref[6]  = 7'h7D; hex_ref[7]  = 7'h07;
        hex_ref[8]  = 7'h7F; hex_ref[9]  = 7'h6F; hex_ref[10] = 7'h77; hex_ref[11] = 7'h7C;
        hex_ref[12] = 7'h39; hex_ref[13] = 7'h5E; hex_ref[14] = 7'h79; hex_ref[15] = 7'h71;

        // Reset held for 5 cycles.
        rst_n = 1'b0;
        @(negedge clk);
        repeat (5) cycle();
        chk("rst_an", int'(an), 'hF);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_dp", int'(dp), 1);
        chk("rst_tick", int'(slot_tick), 0);

        // Release: first edge dead and tickless, tick on the second edge.
        rst_n = 1'b1;
        cycle();
        chk("first_edge_tick", int'(slot_tick), 0);
        chk("first_edge_an", int'(an), 'hF);
        cycle();
        chk("second_edge_tick", int'(slot_tick), 1);

        // Full brightness scan.
        digits_in = 16'h3A91; dp_in = 4'b0100; digit_en = 4'b1111; brightness = 2'd3; load = 1'b1;
        cycle();
        load = 1'b0;
        window(64);
        chk_lits("full", 11, 11, 11, 11);
        chk("full_d0_seg79", d0_79_cnt, 11);
        window(64);
        chk_lits("full2", 11, 11, 11, 11);

        // Blanking digits 1 and 3.
        digit_en = 4'b0101; load = 1'b1;
        cycle();
        load = 1'b0;
        window(64);
        chk_lits("blank", 11, 0, 11, 0);

        // Brightness 1 then 0.
        digit_en = 4'b1111; brightness = 2'd1; load = 1'b1;
        cycle();
        load = 1'b0;
        window(64);
        chk_lits("bright1", 3, 3, 3, 3);
        brightness = 2'd0; load = 1'b1;
        cycle();
        load = 1'b0;
        window(64);
        chk_lits("bright0", 0, 0, 0, 0);

        // Restore full brightness, then change inputs without load.
        brightness = 2'd3; load = 1'b1;
        cycle();
        load = 1'b0;
        digits_in = 16'hFFFF; dp_in = 4'b1111;
        window(64);
        chk_lits("noload", 11, 11, 11, 11);
        chk("noload_d0_seg79", d0_79_cnt, 11);

        // Mid-slot-2 load: next edge is slot 2, offset 5 (lit sub-phase 1).
        for (int i = 0; i < 200; i++) begin
            if ((t_m % DIV) == 5 && ((t_m / DIV) % DIGITS) == 2) break;
            cycle();
        end
        chk("seek_mid_slot2", int'((t_m % DIV) == 5 && ((t_m / DIV) % DIGITS) == 2), 1);
        digits_in = 16'h3591; dp_in = 4'b0100; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("midload_an", int'(an), 'b1011);
        chk("midload_seg", int'(seg), 'h12);
        chk("midload_dp", int'(dp), 0);
        window(64);
        chk_lits("after_midload", 11, 11, 11, 11);

        // Reset mid-operation during the lit phase of slot 2.
        for (int i = 0; i < 200; i++) begin
            if ((t_m % DIV) == 7 && ((t_m / DIV) % DIGITS) == 2) break;
            cycle();
        end
        chk("pre_rst_lit_an", int'(an), 'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", int'(an), 'hF);
        chk("async_rst_seg", int'(seg), 'h7F);
        chk("async_rst_dp", int'(dp), 1);
        chk("async_rst_tick", int'(slot_tick), 0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        chk("rerelease_first_tick", int'(slot_tick), 0);
        cycle();
        chk("rerelease_second_tick", int'(slot_tick), 1);
        window(64);
        chk_lits("after_rst_dark", 0, 0, 0, 0);

        // Reload after reset: scan restarts from digit 0 in the model's frame.
        digits_in = 16'h3A91; dp_in = 4'b0100; digit_en = 4'b1111; brightness = 2'd3; load = 1'b1;
        cycle();
        load = 1'b0;
        window(64);
        chk_lits("after_rst_reload", 11, 11, 11, 11);

        chk("tick_cadence", gap_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
